ysyx_22050598_wb_scoreboard: RTL and testbench

- Writer-side companion to the integer register file.
- Accepts results from two producers, the single-cycle ALU path and the variable-latency LSU/MDU path, through valid/ready handshakes.
- Arbitrates between them and drives the regfile write port (write_en, write_rd_idx, write_rd_data) from a registered stage.
- Keeps a per-register busy scoreboard so the issue stage stalls on RAW and WAW hazards against writes still in flight.

---
 rtl/ysyx_22050598_wb_scoreboard_if.sv | 49 ++++
 rtl/ysyx_22050598_wb_scoreboard.sv | 113 +++++++++++
 tb/tb_ysyx_22050598_wb_scoreboard.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050598_wb_scoreboard_if.sv
// Result/issue/writeback bundle between the pipeline and the writeback scoreboard.
// Combinational only; master drives requests and results, slave answers with ready and commit state.
// Backpressure is carried by the *_ready signals; the slave owns all of them.
interface ysyx_22050598_wb_scoreboard_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int NREG   = 32
);
    logic              issue_valid;
    logic              issue_ready;
    logic [ADDR_W-1:0] issue_rs1_idx;
    logic [ADDR_W-1:0] issue_rs2_idx;
    logic [ADDR_W-1:0] issue_rd_idx;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd_idx;
    logic [DATA_W-1:0] alu_rd_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_rd_idx;
    logic [DATA_W-1:0] lsu_rd_data;

    logic              write_en;
    logic [ADDR_W-1:0] write_rd_idx;
    logic [DATA_W-1:0] write_rd_data;
    logic [NREG-1:0]   busy_vec;
    logic [ADDR_W:0]   outstanding_cnt;
    logic              wb_err;

    modport master (
        output issue_valid, issue_rs1_idx, issue_rs2_idx, issue_rd_idx,
        output alu_valid, alu_rd_idx, alu_rd_data,
        output lsu_valid, lsu_rd_idx, lsu_rd_data,
        input  issue_ready, alu_ready, lsu_ready,
        input  write_en, write_rd_idx, write_rd_data,
        input  busy_vec, outstanding_cnt, wb_err
    );

    modport slave (
        input  issue_valid, issue_rs1_idx, issue_rs2_idx, issue_rd_idx,
        input  alu_valid, alu_rd_idx, alu_rd_data,
        input  lsu_valid, lsu_rd_idx, lsu_rd_data,
        output issue_ready, alu_ready, lsu_ready,
        output write_en, write_rd_idx, write_rd_data,
        output busy_vec, outstanding_cnt, wb_err
    );
endinterface

// File: rtl/ysyx_22050598_wb_scoreboard.sv
// Writeback arbiter (LSU over ALU) plus per-register busy scoreboard for RAW/WAW issue stalls.
// Latency: accepted result reaches the regfile port next cycle; busy clear visible one cycle later.
// Backpressure: LSU never stalled, ALU stalled while LSU valid, issue stalled on any busy operand.
module ysyx_22050598_wb_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int NREG   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_22050598_wb_scoreboard_if.slave sb
);
    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] dat;
    } wb_t;

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;
    logic [NREG-1:0] busy_d;
    logic [ADDR_W:0] cnt_q;
    logic [ADDR_W:0] cnt_d;
    logic            wen_q;
    wb_t             wb_q;
    logic            err_q;

    logic            issue_rdy;
    logic            issue_fire;
    logic            set_any;
    logic            acc_vld;
    wb_t             acc_res;
    logic            commit_hit;
    logic            commit_miss;

    // No forwarding: any operand still in flight blocks issue.
    assign issue_rdy  = !busy_q[sb.issue_rs1_idx] && !busy_q[sb.issue_rs2_idx]
                     && !busy_q[sb.issue_rd_idx];
    assign issue_fire = sb.issue_valid && issue_rdy;
    assign set_any    = issue_fire && (sb.issue_rd_idx != '0);

    always_comb begin
        acc_vld = 1'b0;
        acc_res = '0;
        if (sb.lsu_valid) begin
            acc_vld     = 1'b1;
            acc_res.idx = sb.lsu_rd_idx;
            acc_res.dat = sb.lsu_rd_data;
        end else if (sb.alu_valid) begin
            acc_vld     = 1'b1;
            acc_res.idx = sb.alu_rd_idx;
            acc_res.dat = sb.alu_rd_data;
        end
    end

    assign commit_hit  = wen_q && busy_q[wb_q.idx];
    assign commit_miss = wen_q && !busy_q[wb_q.idx];

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (set_any) begin
            busy_set[sb.issue_rd_idx] = 1'b1;
        end
        if (commit_hit) begin
            busy_clr[wb_q.idx] = 1'b1;
        end
        busy_d    = (busy_q & ~busy_clr) | busy_set;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (set_any && !commit_hit) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!set_any && commit_hit) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            wen_q  <= 1'b0;
            wb_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            wen_q  <= acc_vld && (acc_res.idx != '0);
            if (acc_vld) begin
                wb_q <= acc_res;
            end
            // A commit with nothing outstanding means a producer wrote a register twice or unissued.
            if (commit_miss) begin
                err_q <= 1'b1;
            end
        end
    end

    assign sb.issue_ready     = issue_rdy;
    assign sb.lsu_ready       = 1'b1;
    assign sb.alu_ready       = !sb.lsu_valid;
    assign sb.write_en        = wen_q;
    assign sb.write_rd_idx    = wb_q.idx;
    assign sb.write_rd_data   = wb_q.dat;
    assign sb.busy_vec        = busy_q;
    assign sb.outstanding_cnt = cnt_q;
    assign sb.wb_err          = err_q;
endmodule

// File: tb/tb_ysyx_22050598_wb_scoreboard.sv
// Directed scenarios followed by random traffic, checked against a register-set model.
module tb_ysyx_22050598_wb_scoreboard;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_22050598_wb_scoreboard_if #(.ADDR_W(AW), .DATA_W(DW), .NREG(NR)) bus ();

    ysyx_22050598_wb_scoreboard #(.ADDR_W(AW), .DATA_W(DW), .NREG(NR)) dut (
        .clk (clk),
        .rst (rst_n),
        .sb  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    bit            m_busy [NR];
    bit            m_err;
    bit            m_wen;
    logic [AW-1:0] m_widx;
    logic [DW-1:0] m_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] model_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_busy[i];
        v[0] = 1'b0;
        return v;
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 1; i < NR; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    function automatic bit model_ready();
        return !m_busy[bus.issue_rs1_idx] && !m_busy[bus.issue_rs2_idx] && !m_busy[bus.issue_rd_idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        m_err   = 1'b0;
        m_wen   = 1'b0;
        m_widx  = '0;
        m_wdata = '0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        bit fire;
        fire = bus.issue_valid && model_ready();
        if (m_wen) begin
            if (m_busy[m_widx]) m_busy[m_widx] = 1'b0;
            else m_err = 1'b1;
        end
        if (fire && bus.issue_rd_idx != 0) m_busy[bus.issue_rd_idx] = 1'b1;
        if (bus.lsu_valid) begin
            m_wen = (bus.lsu_rd_idx != 0); m_widx = bus.lsu_rd_idx; m_wdata = bus.lsu_rd_data;
        end else if (bus.alu_valid) begin
            m_wen = (bus.alu_rd_idx != 0); m_widx = bus.alu_rd_idx; m_wdata = bus.alu_rd_data;
        end else begin
            m_wen = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        logic conflict;
        chk({tag, ".issue_ready"}, 64'(bus.issue_ready), 64'(model_ready()));
        chk({tag, ".alu_ready"}, 64'(bus.alu_ready), 64'(!bus.lsu_valid));
        chk({tag, ".lsu_ready"}, 64'(bus.lsu_ready), 64'(1));
        chk({tag, ".write_en"}, 64'(bus.write_en), 64'(m_wen));
        if (m_wen) begin
            chk({tag, ".write_idx"}, 64'(bus.write_rd_idx), 64'(m_widx));
            chk({tag, ".write_data"}, bus.write_rd_data, m_wdata);
        end
        chk({tag, ".busy_vec"}, 64'(bus.busy_vec), 64'(model_vec()));
        chk({tag, ".cnt"}, 64'(bus.outstanding_cnt), 64'(model_cnt()));
        chk({tag, ".wb_err"}, 64'(bus.wb_err), 64'(m_err));
        conflict = bus.write_en && bus.issue_valid && bus.issue_ready &&
                   (bus.issue_rd_idx != 0) && (bus.write_rd_idx == bus.issue_rd_idx);
        chk({tag, ".same_edge"}, 64'(conflict), 64'(0));
    endtask

    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_issue(input bit v, input int rs1, input int rs2, input int rd);
        bus.issue_valid = v; bus.issue_rs1_idx = AW'(rs1);
        bus.issue_rs2_idx = AW'(rs2); bus.issue_rd_idx = AW'(rd);
    endtask

    task automatic set_alu(input bit v, input int rd, input logic [DW-1:0] d);
        bus.alu_valid = v; bus.alu_rd_idx = AW'(rd); bus.alu_rd_data = d;
    endtask

    task automatic set_lsu(input bit v, input int rd, input logic [DW-1:0] d);
        bus.lsu_valid = v; bus.lsu_rd_idx = AW'(rd); bus.lsu_rd_data = d;
    endtask

    task automatic idle();
        set_issue(0, 0, 0, 0); set_alu(0, 0, '0); set_lsu(0, 0, '0);
    endtask

    // Producers mostly retire something that is genuinely outstanding.
    function automatic int pick_rd();
        int list[$];
        if ($urandom_range(0, 99) < 85) begin
            for (int i = 1; i < NR; i++) if (m_busy[i]) list.push_back(i);
            if (list.size() > 0) return list[$urandom_range(0, list.size() - 1)];
        end
        return int'($urandom_range(0, NR - 1));
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset.write_en", 64'(bus.write_en), 64'(0));
        chk("reset.busy_vec", 64'(bus.busy_vec), 64'(0));
        chk("reset.cnt", 64'(bus.outstanding_cnt), 64'(0));
        chk("reset.wb_err", 64'(bus.wb_err), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: issue sets busy, dependent issue stalls
        set_issue(1, 1, 2, 5);
        #1 chk("t1.ready", 64'(bus.issue_ready), 64'(1));
        cycle("t1_fire");
        set_issue(1, 5, 2, 6);
        #1 chk("t1.busy", 64'(bus.busy_vec), 64'h20);
        chk("t1.cnt", 64'(bus.outstanding_cnt), 64'(1));
        chk("t1.stall", 64'(bus.issue_ready), 64'(0));
        cycle("t1_stall");

        // 2: ALU commit, stall released two cycles after acceptance
        set_alu(1, 5, 64'hDEAD);
        cycle("t2_acc");
        set_alu(0, 0, '0);
        #1 chk("t2.wen", 64'(bus.write_en), 64'(1));
        chk("t2.idx", 64'(bus.write_rd_idx), 64'(5));
        chk("t2.data", bus.write_rd_data, 64'hDEAD);
        chk("t2.still_stall", 64'(bus.issue_ready), 64'(0));
        cycle("t2_wb");
        #1 chk("t2.busy_clear", 64'(bus.busy_vec), 64'h0);
        chk("t2.go", 64'(bus.issue_ready), 64'(1));
        cycle("t2_go");
        set_issue(0, 0, 0, 0);
        set_alu(1, 6, 64'h1);
        cycle("t2_drain");
        set_alu(0, 0, '0);
        cycle("t2_drain_wb");
        cycle("t2_drain_clr");

        // 3: simultaneous producers, LSU wins
        set_issue(1, 0, 0, 3);
        cycle("t3_iss3");
        set_issue(1, 0, 0, 4);
        cycle("t3_iss4");
        set_issue(0, 0, 0, 0);
        set_alu(1, 3, 64'h33);
        set_lsu(1, 4, 64'h44);
        #1 chk("t3.alu_blocked", 64'(bus.alu_ready), 64'(0));
        chk("t3.cnt2", 64'(bus.outstanding_cnt), 64'(2));
        cycle("t3_both");
        set_lsu(0, 0, '0);
        #1 chk("t3.idx4", 64'(bus.write_rd_idx), 64'(4));
        chk("t3.alu_ok", 64'(bus.alu_ready), 64'(1));
        cycle("t3_alu");
        set_alu(0, 0, '0);
        #1 chk("t3.idx3", 64'(bus.write_rd_idx), 64'(3));
        chk("t3.wen3", 64'(bus.write_en), 64'(1));
        chk("t3.cnt1", 64'(bus.outstanding_cnt), 64'(1));
        cycle("t3_wb3");
        #1 chk("t3.cnt0", 64'(bus.outstanding_cnt), 64'(0));
        cycle("t3_done");

        // 4: write to x0 is dropped
        set_lsu(1, 0, 64'h1234);
        cycle("t4_acc");
        set_lsu(0, 0, '0);
        #1 chk("t4.wen", 64'(bus.write_en), 64'(0));
        chk("t4.err", 64'(bus.wb_err), 64'(0));
        chk("t4.busy", 64'(bus.busy_vec), 64'h0);
        cycle("t4_after");

        // 5: commit to a non-busy register raises sticky error
        set_alu(1, 7, 64'h77);
        cycle("t5_acc");
        set_alu(0, 0, '0);
        #1 chk("t5.wen", 64'(bus.write_en), 64'(1));
        chk("t5.idx", 64'(bus.write_rd_idx), 64'(7));
        cycle("t5_wb");
        #1 chk("t5.err", 64'(bus.wb_err), 64'(1));
        set_issue(1, 0, 0, 10);
        cycle("t5_iss");
        set_issue(0, 0, 0, 0);
        set_alu(1, 10, 64'hA);
        cycle("t5_alu");
        set_alu(0, 0, '0);
        cycle("t5_wb2");
        #1 chk("t5.err_sticky", 64'(bus.wb_err), 64'(1));
        cycle("t5_idle");

        // 6: reset mid-operation discards everything
        set_issue(1, 0, 0, 3);
        cycle("t6_iss3");
        set_issue(1, 0, 0, 9);
        cycle("t6_iss9");
        set_issue(1, 0, 0, 17);
        cycle("t6_iss17");
        set_issue(0, 0, 0, 0);
        #1 chk("t6.busy", 64'(bus.busy_vec), 64'h20208);
        set_alu(1, 3, 64'h3);
        #1 rst_n = 1'b0;
        #1;
        chk("t6.rst_busy", 64'(bus.busy_vec), 64'h0);
        chk("t6.rst_cnt", 64'(bus.outstanding_cnt), 64'(0));
        chk("t6.rst_err", 64'(bus.wb_err), 64'(0));
        chk("t6.rst_wen", 64'(bus.write_en), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle();
        set_issue(1, 0, 0, 3);
        #1 chk("t6.first_issue", 64'(bus.issue_ready), 64'(1));
        cycle("t6_issue");
        idle();
        cycle("t6_idle");

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            set_issue($urandom_range(0, 1) == 1, int'($urandom_range(0, NR - 1)),
                      int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)));
            set_alu($urandom_range(0, 9) < 4, pick_rd(), {$urandom, $urandom});
            set_lsu($urandom_range(0, 9) < 3, pick_rd(), {$urandom, $urandom});
            #1 chk("rnd.cnt_max", 64'(bus.outstanding_cnt <= AW'(NR - 1)), 64'(1));
            cycle("rnd");
        end
        idle();
        cycle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
